// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: accepts one instruction, issues it to an
// external registered ALU, and writes the result back to a 16x32 regfile.
module alu_issue_ctrl #(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [3:0]  rf_raddr,
  output logic [31:0] rf_rdata,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_funct,
  input  logic [31:0] alu_res,
  output logic        done,
  output logic [3:0]  done_rd,
  output logic [31:0] done_res,
  output logic        err_illegal
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] rf [16];
  logic [3:0]  funct_q;
  logic [3:0]  rd_q;
  logic [3:0]  rs_q;
  logic [3:0]  rt_q;
  logic [4:0]  shamt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  drd_q;
  logic [31:0] dres_q;
  logic        err_q;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        accept;
  logic        legal;
  logic        wb_we;
  logic        ld_we;
  logic        unused_bits;

  assign unused_bits = ^instr[10:0];

  assign accept = instr_valid && instr_ready;
  assign legal  = instr[31:28] <= 4'd8;
  assign wb_we  = (state == WB) && !(R0_ZERO && rd_q == 4'd0);
  assign ld_we  = ld_en && !(R0_ZERO && ld_addr == 4'd0);

  always_comb begin
    rs_val   = rf[rs_q];
    rt_val   = rf[rt_q];
    rf_rdata = rf[rf_raddr];
    if (R0_ZERO && rs_q == 4'd0) rs_val = '0;
    if (R0_ZERO && rt_q == 4'd0) rt_val = '0;
    if (R0_ZERO && rf_raddr == 4'd0) rf_rdata = '0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && legal) state_nx = ISSUE;
      ISSUE:   state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands are live during ISSUE, then frozen until the next ISSUE.
  always_comb begin
    instr_ready = (state == IDLE) && rst_n;
    alu_a       = (state == ISSUE) ? rs_val : a_q;
    alu_b       = (state == ISSUE) ? rt_val : b_q;
    alu_shamt   = shamt_q;
    alu_funct   = funct_q;
    done        = (state == WB);
    done_rd     = done ? rd_q : drd_q;
    done_res    = done ? alu_res : dres_q;
    err_illegal = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      funct_q <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      shamt_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      drd_q   <= '0;
      dres_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && legal) begin
        funct_q <= instr[31:28];
        rd_q    <= instr[27:24];
        rs_q    <= instr[23:20];
        rt_q    <= instr[19:16];
        shamt_q <= instr[15:11];
      end
      if (accept && !legal) err_q <= 1'b1;
      if (state == ISSUE) begin
        a_q <= rs_val;
        b_q <= rt_val;
      end
      if (state == WB) begin
        drd_q  <= rd_q;
        dres_q <= alu_res;
      end
    end
  end

  // Writeback takes priority over a direct load to the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wb_we && rd_q == 4'(i))
          rf[i] <= alu_res;
        else if (ld_we && ld_addr == 4'(i))
          rf[i] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  rf_raddr = '0;
  logic [31:0] rf_rdata;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;
  logic [31:0] alu_res = '0;
  logic        done;
  logic [3:0]  done_rd;
  logic [31:0] done_res;
  logic        err_illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl #(.R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_res(alu_res),
    .done(done), .done_rd(done_rd), .done_res(done_res),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (alu_funct)
      4'd0: alu_res <= alu_a + alu_b;
      4'd1: alu_res <= alu_a - alu_b;
      4'd2: alu_res <= alu_a & alu_b;
      4'd3: alu_res <= alu_a | alu_b;
      4'd4: alu_res <= alu_a ^ alu_b;
      4'd5: alu_res <= ~alu_a;
      4'd6: alu_res <= alu_a << alu_shamt;
      4'd7: alu_res <= $signed(alu_a) >>> alu_shamt;
      4'd8: alu_res <= alu_a >> alu_shamt;
      default: alu_res <= '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] f,
      input logic [3:0] rd, input logic [3:0] rs,
      input logic [3:0] rt, input logic [4:0] sh);
    return {f, rd, rs, rt, sh, 11'd0};
  endfunction

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  function automatic logic [31:0] rd_rf(input logic [3:0] a);
    return dut.rf_rdata;
  endfunction

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    rf_raddr = a;
    #1;
    v = rf_rdata;
  endtask

  // Issue one instruction; returns result and accept-to-done latency.
  task automatic issue(input logic [31:0] ins, output logic [31:0] res,
                       output int lat);
    int k;
    res = 'x;
    lat = -1;
    instr = ins;
    instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 10) begin
      tick();
      k++;
    end
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (done) begin
        res = done_res;
        lat = c;
        break;
      end
      tick();
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] v;
  logic [31:0] r;
  int          lat;
  int          acc_cyc[$];
  logic [3:0]  drd_seq[$];

  initial begin
    vecs[0] = '{mk(4'd0, 4'd9,  4'd1, 4'd2, 5'd0), 4'd9,  32'h0000_0008};
    vecs[1] = '{mk(4'd1, 4'd10, 4'd1, 4'd2, 5'd0), 4'd10, 32'h0000_0002};
    vecs[2] = '{mk(4'd2, 4'd11, 4'd8, 4'd1, 5'd0), 4'd11, 32'h0000_0004};
    vecs[3] = '{mk(4'd3, 4'd12, 4'd7, 4'd1, 5'd0), 4'd12, 32'h8000_0005};
    vecs[4] = '{mk(4'd4, 4'd13, 4'd8, 4'd8, 5'd0), 4'd13, 32'h0000_0000};
    vecs[5] = '{mk(4'd5, 4'd14, 4'd1, 4'd0, 5'd0), 4'd14, 32'hFFFF_FFFA};
    vecs[6] = '{mk(4'd6, 4'd15, 4'd1, 4'd0, 5'd3), 4'd15, 32'h0000_0028};
    vecs[7] = '{mk(4'd7, 4'd9,  4'd7, 4'd0, 5'd4), 4'd9,  32'hF800_0000};
    vecs[8] = '{mk(4'd8, 4'd10, 4'd7, 4'd0, 5'd4), 4'd10, 32'h0800_0000};
    vecs[9] = '{mk(4'd1, 4'd11, 4'd2, 4'd1, 5'd0), 4'd11, 32'hFFFF_FFFE};

    // reset state
    #2;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    // basic ADD with latency and ready profile
    load(4'd1, 32'd5);
    load(4'd2, 32'd3);
    instr = mk(4'd0, 4'd3, 4'd1, 4'd2, 5'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("add_issue_ready", 32'(instr_ready), 32'd0);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd3);
    chk("add_issue_done", 32'(done), 32'd0);
    tick();
    chk("add_wb_ready", 32'(instr_ready), 32'd0);
    chk("add_done", 32'(done), 32'd1);
    chk("add_done_rd", 32'(done_rd), 32'd3);
    chk("add_done_res", done_res, 32'd8);
    tick();
    chk("add_idle_done", 32'(done), 32'd0);
    chk("add_ready_back", 32'(instr_ready), 32'd1);
    chk("add_res_held", done_res, 32'd8);
    chk("add_alu_a_held", alu_a, 32'd5);
    peek(4'd3, v);
    chk("add_rf3", v, 32'd8);

    // table of ops
    load(4'd7, 32'h8000_0000);
    load(4'd8, 32'hF0F0_1234);
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].ins, r, lat);
      chk($sformatf("vec%0d_res", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      peek(vecs[i].rd, v);
      chk($sformatf("vec%0d_rf", i), v, vecs[i].exp);
    end

    // SRA then SRL on r1 = 0x8000_0000
    load(4'd1, 32'h8000_0000);
    issue(mk(4'd7, 4'd4, 4'd1, 4'd0, 5'd4), r, lat);
    peek(4'd4, v);
    chk("sra_rf4", v, 32'hF800_0000);
    issue(mk(4'd8, 4'd4, 4'd1, 4'd0, 5'd4), r, lat);
    peek(4'd4, v);
    chk("srl_rf4", v, 32'h0800_0000);

    // rd == rs uses the pre-write operand
    load(4'd5, 32'd10);
    issue(mk(4'd0, 4'd5, 4'd5, 4'd5, 5'd0), r, lat);
    peek(4'd5, v);
    chk("rd_eq_rs", v, 32'd20);

    // illegal funct
    instr = mk(4'd12, 4'd6, 4'd1, 4'd2, 5'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_ready", 32'(instr_ready), 32'd1);
    chk("ill_funct_kept", 32'(alu_funct), 32'd0);
    begin
      int nd = 0;
      for (int c = 0; c < 4; c++) begin
        if (done) nd++;
        tick();
      end
      chk("ill_no_done", 32'(nd), 32'd0);
    end
    chk("ill_sticky", 32'(err_illegal), 32'd1);

    // r0 stays zero, done still pulses
    load(4'd1, 32'd5);
    load(4'd0, 32'h1234_5678);
    peek(4'd0, v);
    chk("r0_ld_ignored", v, 32'd0);
    issue(mk(4'd0, 4'd0, 4'd1, 4'd2, 5'd0), r, lat);
    chk("r0_done_lat", 32'(lat), 32'd2);
    chk("r0_done_res", r, 32'd8);
    peek(4'd0, v);
    chk("r0_reads_zero", v, 32'd0);

    // direct load collides with writeback: writeback wins
    instr = mk(4'd0, 4'd5, 4'd1, 4'd2, 5'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("coll_done", 32'(done), 32'd1);
    ld_en = 1'b1;
    ld_addr = 4'd5;
    ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    peek(4'd5, v);
    chk("coll_wb_wins", v, 32'd8);

    // reset during ISSUE aborts the instruction
    instr = mk(4'd1, 4'd6, 4'd1, 4'd2, 5'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("abort_in_issue", 32'(alu_funct), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(instr_ready), 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_alu_b", alu_b, 32'd0);
    chk("abort_shamt_funct", {alu_shamt, alu_funct}, 32'd0);
    chk("abort_done", {done, done_rd}, 32'd0);
    chk("abort_done_res", done_res, 32'd0);
    chk("abort_err", 32'(err_illegal), 32'd0);
    peek(4'd6, v);
    chk("abort_rf6", v, 32'd0);
    peek(4'd1, v);
    chk("abort_rf1", v, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(instr_ready), 32'd1);
    begin
      int nd = 0;
      for (int c = 0; c < 3; c++) begin
        if (done) nd++;
        tick();
      end
      chk("abort_no_done", 32'(nd), 32'd0);
    end

    // back-to-back with valid held high
    load(4'd1, 32'd1);
    begin
      int n_acc = 0;
      instr = mk(4'd0, 4'd9, 4'd1, 4'd1, 5'd0);
      instr_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
        logic acc;
        acc = instr_valid && instr_ready;
        tick();
        if (done) drd_seq.push_back(done_rd);
        if (acc) begin
          acc_cyc.push_back(c);
          n_acc++;
          if (n_acc == 3) instr_valid = 1'b0;
          else instr = mk(4'd0, 4'(9 + n_acc), 4'd1, 4'd1, 5'd0);
        end
      end
      instr_valid = 1'b0;
    end
    chk("b2b_n_acc", 32'(acc_cyc.size()), 32'd3);
    chk("b2b_n_done", 32'(drd_seq.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
      chk("b2b_acc1", 32'(acc_cyc[1]), 32'd3);
      chk("b2b_acc2", 32'(acc_cyc[2]), 32'd6);
    end
    if (drd_seq.size() == 3) begin
      chk("b2b_rd0", 32'(drd_seq[0]), 32'd9);
      chk("b2b_rd1", 32'(drd_seq[1]), 32'd10);
      chk("b2b_rd2", 32'(drd_seq[2]), 32'd11);
    end
    peek(4'd11, v);
    chk("b2b_rf11", v, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
